// File: rtl/sram_1r1w_be_if.sv
// Bus bundle for the 1R1W byte-enable SRAM: read port, write port and init status.
interface sram_1r1w_be_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
);
  localparam int unsigned BYTES = DATA_WIDTH / 8;

  logic                  init_done;
  logic                  read_en;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_valid;
  logic                  write_en;
  logic [BYTES-1:0]      write_byte_en;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;

  modport master (
    output read_en, read_addr, write_en, write_byte_en, write_addr, write_data,
    input  init_done, read_data, read_valid
  );

  modport slave (
    input  read_en, read_addr, write_en, write_byte_en, write_addr, write_data,
    output init_done, read_data, read_valid
  );
endinterface

// File: rtl/sram_1r1w_be.sv
// Simple dual-port block SRAM: one read port, one write port, per-byte write enables,
// read latency of 1 or 2 cycles with a valid strobe, selectable read-during-write rule
// and an optional zero-fill sequencer that runs after reset.
module sram_1r1w_be #(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned SIZE              = 1024,
  parameter int unsigned READ_LATENCY      = 1,
  parameter string       READ_DURING_WRITE = "NEW_DATA",
  parameter int unsigned CLEAR_ON_RESET    = 1,
  parameter int unsigned ADDR_WIDTH        = $clog2(SIZE),
  parameter int unsigned BYTES             = DATA_WIDTH / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  sram_1r1w_be_if.slave     bus
);

  // Elaboration-time parameter checks.
  if ((DATA_WIDTH == 0) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_data_width
    $fatal(1, "sram_1r1w_be: DATA_WIDTH must be a nonzero multiple of 8");
  end
  if (SIZE < 2) begin : g_bad_size
    $fatal(1, "sram_1r1w_be: SIZE must be at least 2");
  end
  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
    $fatal(1, "sram_1r1w_be: READ_LATENCY must be 1 or 2");
  end
  if ((READ_DURING_WRITE != "NEW_DATA") && (READ_DURING_WRITE != "OLD_DATA") &&
      (READ_DURING_WRITE != "DONT_CARE")) begin : g_bad_rdw
    $fatal(1, "sram_1r1w_be: READ_DURING_WRITE must be NEW_DATA, OLD_DATA or DONT_CARE");
  end
  if (CLEAR_ON_RESET > 1) begin : g_bad_clear
    $fatal(1, "sram_1r1w_be: CLEAR_ON_RESET must be 0 or 1");
  end

  // DONT_CARE shares the OLD_DATA path: it is the cheapest legal answer.
  localparam bit IsNewData = (READ_DURING_WRITE == "NEW_DATA");

  // One extra bit so SIZE itself is representable when SIZE is a power of two.
  localparam logic [ADDR_WIDTH:0]   SizeW    = (ADDR_WIDTH + 1)'(SIZE);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(SIZE - 1);

  typedef enum logic [0:0] {StInit, StReady} state_e;

  localparam state_e ResetState = (CLEAR_ON_RESET != 0) ? StInit : StReady;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  init_we;

  logic                  ready;
  logic                  rd_accept;
  logic                  rd_in_range;
  logic                  wr_in_range;
  logic                  wr_accept;
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [BYTES-1:0]      mem_be;
  logic [DATA_WIDTH-1:0] mem [SIZE];

  logic                  s1_valid_q;
  logic [DATA_WIDTH-1:0] s1_data_q;

  assign ready         = (state_q == StReady);
  assign bus.init_done = ready;

  assign rd_in_range = ((ADDR_WIDTH + 1)'(bus.read_addr) < SizeW);
  assign wr_in_range = ((ADDR_WIDTH + 1)'(bus.write_addr) < SizeW);
  assign rd_accept   = ready & bus.read_en;
  assign wr_accept   = ready & bus.write_en & wr_in_range;

  // Init FSM state and fill counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ResetState;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Next-state: walk the array once writing zeros, then park in READY until reset.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    init_we    = 1'b0;
    unique case (state_q)
      StInit: begin
        init_we    = 1'b1;
        init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
        if (init_cnt_q == LastAddr) begin
          state_d = StReady;
        end
      end
      StReady: begin
      end
    endcase
  end

  // Select the array write source: fill sequencer during INIT, user port otherwise.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = bus.write_addr;
    mem_wdata = bus.write_data;
    mem_be    = bus.write_byte_en;
    if (init_we) begin
      mem_we    = 1'b1;
      mem_addr  = init_cnt_q;
      mem_wdata = '0;
      mem_be    = '1;
    end else if (wr_accept) begin
      mem_we = 1'b1;
    end
    // No array update while reset is held.
    if (!reset_n) begin
      mem_we = 1'b0;
    end
  end

  // Array write with per-lane enables; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (mem_be[b]) begin
          mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read word at the accept edge, including same-address write forwarding for NEW_DATA.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[bus.read_addr];
      if (IsNewData && wr_accept && (bus.write_addr == bus.read_addr)) begin
        for (int unsigned b = 0; b < BYTES; b++) begin
          if (bus.write_byte_en[b]) begin
            rd_word[8*b +: 8] = bus.write_data[8*b +: 8];
          end
        end
      end
    end
  end

  // First output stage; data only moves on an accepted read so it holds otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_accept;
      if (rd_accept) begin
        s1_data_q <= rd_word;
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s2_valid_q;
    logic [DATA_WIDTH-1:0] s2_data_q;

    // Second output stage, loaded only when stage one carries a result.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= s1_data_q;
        end
      end
    end

    assign bus.read_valid = s2_valid_q;
    assign bus.read_data  = s2_data_q;
  end else begin : g_lat1
    assign bus.read_valid = s1_valid_q;
    assign bus.read_data  = s1_data_q;
  end

endmodule

// File: doc/sram_1r1w_be.md
Name: sram_1r1w_be

Overview:
- Second-generation simple dual-port block SRAM: one read port, one write port, single clock.
- Adds per-byte write enables, a selectable read latency of 1 or 2 with a `read_valid` strobe, and a third read-during-write mode (`OLD_DATA`).
- Adds an optional hardware zero-fill sequencer that runs after reset.
- Used for coefficient/scratch buffers in the RLWE core, where deterministic initial contents and partial-word updates are required.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- SIZE, 1024, number of words; must be >= 2; need not be a power of two.
- READ_LATENCY, 1, cycles from accepted read to `read_valid`; legal values 1 or 2.
- READ_DURING_WRITE, "NEW_DATA", same-address read/write collision rule; one of "NEW_DATA", "OLD_DATA", "DONT_CARE".
- CLEAR_ON_RESET, 1, 1 = zero-fill the whole array after reset; 0 = contents undefined, ready immediately.
- ADDR_WIDTH, $clog2(SIZE), address width; derived, do not override.
- BYTES, DATA_WIDTH/8, number of byte lanes; derived.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- init_done  output  1  high when the block accepts reads and writes.
- read_en  input  1  read request.
- read_addr  input  ADDR_WIDTH  read word address.
- read_data  output  DATA_WIDTH  read result; qualified by `read_valid`.
- read_valid  output  1  `read_data` holds the result of an accepted read.
- write_en  input  1  write request.
- write_byte_en  input  BYTES  per-lane write mask; bit i covers `write_data[8i+7:8i]`.
- write_addr  input  ADDR_WIDTH  write word address.
- write_data  input  DATA_WIDTH  write data.

Behaviour:
- Elaboration check: an illegal DATA_WIDTH, SIZE, READ_LATENCY or READ_DURING_WRITE value is a fatal elaboration error.

Reset (`reset_n` low, asynchronous):
- `read_valid` = 0, `read_data` = 0, all pipeline stages cleared.
- Init counter = 0.
- FSM = INIT if CLEAR_ON_RESET = 1, else READY.
- `init_done` = 0 if CLEAR_ON_RESET = 1, else 1.
- The memory array itself is not reset.

FSM:
- INIT: each cycle writes all-zero to word `init_cnt` and increments the counter.
- When `init_cnt` = SIZE-1 is written, the next state is READY.
- `init_done` rises on the edge after the last zero write, so it is high exactly SIZE cycles after `reset_n` deasserts.
- READY: terminal state; left only by reset.
- Reset asserted mid-INIT aborts the fill; it restarts from word 0 after release.
- While `init_done` = 0, `read_en` and `write_en` are ignored: no array update, `read_valid` stays 0.

Write (READY):
- On a rising edge with `write_en` = 1, lane i of `mem[write_addr]` is updated if `write_byte_en[i]` = 1.
- Other lanes keep their value.
- `write_en` with `write_byte_en` = 0 is a no-op.
- `write_addr` >= SIZE: write is discarded.

Read (READY):
- A read is accepted on any edge with `read_en` = 1.
- The value is sampled at the accept edge; later writes never change an in-flight result.
- READ_LATENCY = 1: `read_data`/`read_valid` update on the accept edge, visible the following cycle.
- READ_LATENCY = 2: one extra output register stage; result appears one cycle later.
- Fully pipelined: back-to-back reads on every cycle give `read_valid` continuously high, results in request order.
- `read_valid` = 1 for exactly one cycle per accepted read.
- When no result is due, `read_valid` = 0 and `read_data` holds its last value (no X).
- `read_addr` >= SIZE: returns 0 with `read_valid` = 1.

Read-during-write (same address, same edge, both enabled):
- NEW_DATA: result = masked merge; lanes with `write_byte_en` = 1 come from `write_data`, other lanes are old contents.
- OLD_DATA: result = contents before the write.
- DONT_CARE: result unspecified (may be X in simulation); `read_valid` timing still holds.
- Different addresses: no interaction.
- The write always completes regardless of the collision mode.

Test Plan:
- Init fill: CLEAR_ON_RESET = 1, SIZE = 16; release `reset_n` -> `init_done` rises at cycle 16; read of every address -> 0x00000000.
- Mid-init reset: pulse `reset_n` low at init cycle 5 -> `init_done` stays low, then rises 16 cycles after the second release; accesses during INIT -> `read_valid` never asserts.
- Byte enables: write 0xAABBCCDD to addr 3 with mask 4'hF, then 0x11223344 with mask 4'b0101 -> read addr 3 = 0xAA22CC44.
- Latency and streaming: READ_LATENCY = 2, reads to addrs 0..7 on consecutive cycles -> `read_valid` high for 8 cycles starting 2 cycles after the first `read_en`, data in order; `read_data` holds the last value afterwards.
- Collision, NEW_DATA: addr 5 = 0x12345678; same-edge read plus write 0xFFFFFFFF with mask 4'b0011 -> read = 0x1234FFFF. With OLD_DATA, same stimulus -> read = 0x12345678, and a subsequent read = 0x1234FFFF.
- Out of range: SIZE = 12; write addr 13 then read addr 13 -> `read_data` = 0 with `read_valid` = 1; addrs 0..11 unchanged.
